// File: rtl/softshell_mailbox_wb_pkg.sv
// +----------------------------------------------------------------------+
// | softshell_mailbox_wb_pkg                                             |
// | Mailbox register offsets, STATUS/CTRL bit positions, status packing. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package softshell_mailbox_wb_pkg;

  // Byte offsets of the registers inside one mailbox window.
  localparam logic [3:0]  c_MBOX_DATA   = 4'h0;
  localparam logic [3:0]  c_MBOX_STATUS = 4'h4;
  localparam logic [3:0]  c_MBOX_CTRL   = 4'h8;
  localparam logic [31:0] c_MBOX_STRIDE = 32'h10;

  localparam int c_STAT_EMPTY   = 0;
  localparam int c_STAT_FULL    = 1;
  localparam int c_STAT_OVF     = 2;
  localparam int c_STAT_UDF     = 3;
  localparam int c_STAT_CNT_LSB = 4;

  localparam int c_CTRL_FLUSH   = 0;
  localparam int c_CTRL_CLRFLG  = 1;

  function automatic logic [31:0] f_status(input logic       i_empty,
                                           input logic       i_full,
                                           input logic       i_ovf,
                                           input logic       i_udf,
                                           input logic [3:0] i_cnt);
    logic [31:0] w_s;
    w_s                       = '0;
    w_s[c_STAT_EMPTY]         = i_empty;
    w_s[c_STAT_FULL]          = i_full;
    w_s[c_STAT_OVF]           = i_ovf;
    w_s[c_STAT_UDF]           = i_udf;
    w_s[c_STAT_CNT_LSB +: 4]  = i_cnt;
    return w_s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/softshell_mailbox_wb_mbox_fifo.sv
// +----------------------------------------------------------------------+
// | mbox_fifo                                                            |
// | One 32-bit mailbox FIFO with flush and sticky over/underflow flags.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mbox_fifo #(
  parameter int  DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic          i_clr_flags,
  input  logic [31:0]   i_din,
  output logic [31:0]   o_dout,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_overflow,
  output logic          o_underflow
);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic          r_udf;
  logic          w_full;
  logic          w_empty;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push & ~w_full;
  assign w_do_pop  = i_pop & ~w_empty;

  // Flush wins over push/pop; flags are handled independently of flush.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (i_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
      if (i_clr_flags) begin
        r_ovf <= 1'b0;
        r_udf <= 1'b0;
      end else begin
        r_ovf <= r_ovf | (i_push & w_full);
        r_udf <= r_udf | (i_pop & w_empty);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
  end

  assign o_dout      = r_mem[r_rd_ptr];
  assign o_count     = r_count;
  assign o_full      = w_full;
  assign o_empty     = w_empty;
  assign o_overflow  = r_ovf;
  assign o_underflow = r_udf;

endmodule

`default_nettype wire

// File: rtl/softshell_mailbox_wb.sv
// +----------------------------------------------------------------------+
// | softshell_mailbox_wb                                                 |
// | Wishbone slave with one message FIFO per core; decode, ack, read mux.|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module softshell_mailbox_wb
  import softshell_mailbox_wb_pkg::*;
#(
  parameter int NUM_MBOX = 4,
  parameter int DEPTH    = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [31:0]         wb_adr_i,
  input  logic [31:0]         wb_dat_i,
  input  logic [3:0]          wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  output logic                wb_ack_o,
  output logic [31:0]         wb_dat_o,
  output logic [NUM_MBOX-1:0] mbox_nempty_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                w_accept;
  logic [1:0]          w_idx;
  logic [3:0]          w_off;
  logic                w_hit;
  logic [31:0]         w_rdata;
  logic                w_unused;
  logic [31:0]         w_dout  [NUM_MBOX];
  logic [CW-1:0]       w_count [NUM_MBOX];
  logic [NUM_MBOX-1:0] w_full;
  logic [NUM_MBOX-1:0] w_empty;
  logic [NUM_MBOX-1:0] w_ovf;
  logic [NUM_MBOX-1:0] w_udf;
  logic                r_ack;
  logic [31:0]         r_dat;

  assign w_accept = wb_cyc_i & wb_stb_i & ~r_ack;
  assign w_idx    = wb_adr_i[5:4];
  assign w_off    = {wb_adr_i[3:2], 2'b00};
  assign w_hit    = (32'(w_idx) < 32'(NUM_MBOX));
  assign w_unused = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0]};

  for (genvar n = 0; n < NUM_MBOX; n++) begin : g_mbox
    logic w_sel;
    logic w_wr_ctrl;
    assign w_sel     = w_accept & w_hit & (w_idx == 2'(n));
    assign w_wr_ctrl = w_sel & wb_we_i & (w_off == c_MBOX_CTRL);

    mbox_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk       (wb_clk_i),
      .i_rst       (wb_rst_i),
      .i_push      (w_sel & wb_we_i & (w_off == c_MBOX_DATA)),
      .i_pop       (w_sel & ~wb_we_i & (w_off == c_MBOX_DATA)),
      .i_flush     (w_wr_ctrl & wb_dat_i[c_CTRL_FLUSH]),
      .i_clr_flags (w_wr_ctrl & wb_dat_i[c_CTRL_CLRFLG]),
      .i_din       (wb_dat_i),
      .o_dout      (w_dout[n]),
      .o_count     (w_count[n]),
      .o_full      (w_full[n]),
      .o_empty     (w_empty[n]),
      .o_overflow  (w_ovf[n]),
      .o_underflow (w_udf[n])
    );

    assign mbox_nempty_o[n] = (w_count[n] != '0);
  end

  // Pre-edge view: popped head or STATUS as it stands before the accept edge.
  always_comb begin
    w_rdata = '0;
    for (int n = 0; n < NUM_MBOX; n++) begin
      if (w_hit && (w_idx == 2'(n))) begin
        case (w_off)
          c_MBOX_DATA:   if (!w_empty[n]) w_rdata = w_dout[n];
          c_MBOX_STATUS: w_rdata = f_status(w_empty[n], w_full[n], w_ovf[n],
                                            w_udf[n], 4'(w_count[n]));
          default:       w_rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_accept;
      r_dat <= (w_accept && !wb_we_i) ? w_rdata : '0;
    end
  end

  assign wb_ack_o = r_ack;
  assign wb_dat_o = r_dat;

endmodule

`default_nettype wire

// File: tb/tb_softshell_mailbox_wb.sv
// +----------------------------------------------------------------------+
// | tb_softshell_mailbox_wb                                              |
// | Directed scoreboard bench for the mailbox Wishbone slave.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_softshell_mailbox_wb;
  import softshell_mailbox_wb_pkg::*;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_we_i  = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  mbox_nempty_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] sb_exp[$];
  string       sb_tag[$];

  softshell_mailbox_wb #(.NUM_MBOX(4), .DEPTH(4)) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .wb_adr_i      (wb_adr_i),
    .wb_dat_i      (wb_dat_i),
    .wb_sel_i      (wb_sel_i),
    .wb_we_i       (wb_we_i),
    .wb_cyc_i      (wb_cyc_i),
    .wb_stb_i      (wb_stb_i),
    .wb_ack_o      (wb_ack_o),
    .wb_dat_o      (wb_dat_o),
    .mbox_nempty_o (mbox_nempty_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr(input int m, input logic [3:0] off);
    return 32'(m) * c_MBOX_STRIDE + {28'h0, off};
  endfunction

  // One Wishbone access; reads pop the scoreboard when the ack arrives.
  task automatic bus(input logic [31:0] adr, input logic we, input logic [31:0] dat);
    int          lat;
    logic [31:0] rd;
    logic [31:0] exp;
    string       tag;
    @(negedge wb_clk_i);
    wb_adr_i = adr; wb_we_i = we; wb_dat_i = dat;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    lat = 0;
    do begin
      @(posedge wb_clk_i); #1;
      lat++;
    end while (!wb_ack_o && lat < 8);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    rd = wb_dat_o;
    check($sformatf("ack_latency@%0h", adr), 32'(lat), 32'd1);
    if (!we) begin
      if (sb_exp.size() == 0) begin
        check("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        exp = sb_exp.pop_front();
        tag = sb_tag.pop_front();
        check(tag, rd, exp);
      end
    end
    @(posedge wb_clk_i); #1;
    check($sformatf("ack_pulse@%0h", adr), {31'h0, wb_ack_o}, 32'd0);
    check($sformatf("dat_idle@%0h", adr), wb_dat_o, 32'd0);
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    sb_exp.push_back(exp);
    sb_tag.push_back(tag);
    bus(adr, 1'b0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat);
    bus(adr, 1'b1, dat);
  endtask

  initial begin
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_ack", {31'h0, wb_ack_o}, 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_nempty", {28'h0, mbox_nempty_o}, 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    rd(addr(0, c_MBOX_STATUS), 32'h0000_0001, "m0_status_reset");
    rd(addr(0, c_MBOX_CTRL),   32'h0000_0000, "m0_ctrl_reads_0");

    // Fill mbox1 and drain it.
    for (int i = 1; i <= 4; i++) wr(addr(1, c_MBOX_DATA), 32'hA5A5_0000 + 32'(i));
    rd(addr(1, c_MBOX_STATUS), 32'h0000_0042, "m1_status_full");
    check("m1_nempty_set", {28'h0, mbox_nempty_o}, 32'h2);
    for (int i = 1; i <= 4; i++)
      rd(addr(1, c_MBOX_DATA), 32'hA5A5_0000 + 32'(i), $sformatf("m1_pop%0d", i));
    rd(addr(1, c_MBOX_STATUS), 32'h0000_0001, "m1_status_drained");
    check("m1_nempty_clr", {28'h0, mbox_nempty_o}, 32'h0);

    // Overflow on mbox2.
    for (int i = 0; i < 5; i++) wr(addr(2, c_MBOX_DATA), 32'hB000_0000 + 32'(i));
    rd(addr(2, c_MBOX_STATUS), 32'h0000_0046, "m2_status_ovf");
    wr(addr(2, c_MBOX_STATUS), 32'hFFFF_FFFF);
    wr(addr(2, 4'hC), 32'hFFFF_FFFF);
    wr(addr(2, c_MBOX_CTRL), 32'h2);
    rd(addr(2, c_MBOX_STATUS), 32'h0000_0042, "m2_status_clrflg");
    for (int i = 0; i < 4; i++)
      rd(addr(2, c_MBOX_DATA), 32'hB000_0000 + 32'(i), $sformatf("m2_pop%0d", i));

    // Underflow on mbox3.
    rd(addr(3, c_MBOX_DATA),   32'h0000_0000, "m3_pop_empty");
    rd(addr(3, c_MBOX_STATUS), 32'h0000_0009, "m3_status_udf");
    wr(addr(3, c_MBOX_CTRL), 32'h3);
    rd(addr(3, c_MBOX_STATUS), 32'h0000_0001, "m3_status_ctrl3");

    // Pointer wrap on mbox0.
    for (int i = 0; i < 6; i++) begin
      wr(addr(0, c_MBOX_DATA), 32'hC0DE_0000 + 32'(i));
      rd(addr(0, c_MBOX_DATA), 32'hC0DE_0000 + 32'(i), $sformatf("m0_pair%0d", i));
    end
    for (int i = 0; i < 3; i++) wr(addr(0, c_MBOX_DATA), 32'hD00D_0000 + 32'(i));
    rd(addr(0, c_MBOX_STATUS), 32'h0000_0030, "m0_status_cnt3");
    rd(addr(0, c_MBOX_DATA), 32'hD00D_0000, "m0_wrap_pop0");
    rd(addr(0, c_MBOX_DATA), 32'hD00D_0001, "m0_wrap_pop1");
    rd(addr(0, c_MBOX_STATUS), 32'h0000_0010, "m0_status_cnt1");
    wr(addr(0, c_MBOX_CTRL), 32'h1);
    rd(addr(0, c_MBOX_STATUS), 32'h0000_0001, "m0_status_flushed");
    check("m0_nempty_flushed", {28'h0, mbox_nempty_o}, 32'h0);

    // Reset coinciding with an accepted DATA write.
    wr(addr(1, c_MBOX_DATA), 32'h1234_5678);
    check("m1_nempty_pre_rst", {28'h0, mbox_nempty_o}, 32'h2);
    @(negedge wb_clk_i);
    wb_adr_i = addr(1, c_MBOX_DATA); wb_we_i = 1'b1; wb_dat_i = 32'hDEAD_BEEF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check("rst_mid_ack", {31'h0, wb_ack_o}, 32'd0);
    @(negedge wb_clk_i);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    check("rst_mid_ack2", {31'h0, wb_ack_o}, 32'd0);
    check("rst_mid_nempty", {28'h0, mbox_nempty_o}, 32'h0);
    rd(addr(1, c_MBOX_STATUS), 32'h0000_0001, "m1_status_post_rst");

    check("scoreboard_drained", 32'(sb_exp.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
